// File: rtl/riscv_pkg.sv
// Shared types and constants for the branch resolution / prediction logic.
package riscv_pkg;

  // 2-bit saturating branch counter states.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_t;

  localparam int unsigned DEFAULT_ENTRIES = 16;

endpackage

// File: rtl/sat_counter.sv
// 2-bit saturating up/down counter with enable and parallel load.
// Reset lands on WNT so a fresh entry leans not-taken.
module sat_counter
  import riscv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [1:0] i_load_val,
  output logic [1:0] o_cnt
);

  logic [1:0] r_cnt;

  // Counter state: reset has priority, then load, then saturating step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= WNT;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      if (i_up && (r_cnt != ST)) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (!i_up && (r_cnt != SNT)) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with an optional direct-mapped branch
// predictor (tag, target, 2-bit counter per entry).
// Macro BRANCH_PREDICT_EN enables the predictor table; without it the
// block is a static not-taken resolver with no table storage.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = DEFAULT_ENTRIES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic [WIDTH-1:0] PCE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             BneE,
  input  logic             EQ,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  input  logic             StallE,
  output logic             RedirectE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic             FlushD,
  output logic             FlushE
);

  logic w_resolve;
  logic w_actual_taken;
  logic w_mispredict;
  logic w_unused;

  assign w_resolve      = (BranchE | JumpE) & ~StallE;
  assign w_actual_taken = JumpE | (BranchE & (EQ ^ BneE));

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [WIDTH-1:0]   r_target [ENTRIES];
  logic [1:0]         w_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_idx_f;
  logic [IDX_W-1:0] w_idx_e;
  logic [TAG_W-1:0] w_tag_f;
  logic [TAG_W-1:0] w_tag_e;
  logic             w_hit_e;
  logic             w_alloc;

  assign w_idx_f = PCF[IDX_W+1:2];
  assign w_tag_f = PCF[WIDTH-1:IDX_W+2];
  assign w_idx_e = PCE[IDX_W+1:2];
  assign w_tag_e = PCE[WIDTH-1:IDX_W+2];
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  // Only a taken branch claims a missing entry; not-taken misses leave it.
  assign w_alloc = w_resolve & ~w_hit_e & w_actual_taken;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_idx_e == IDX_W'(g));
    sat_counter u_cnt (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (w_resolve & w_sel & w_hit_e),
      .i_up       (w_actual_taken),
      .i_load     (w_alloc & w_sel),
      .i_load_val (WT),
      .o_cnt      (w_cnt[g])
    );
  end

  // Table update: allocate on taken miss, refresh target on taken hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_idx_e]  <= 1'b1;
      r_tag[w_idx_e]    <= w_tag_e;
      r_target[w_idx_e] <= PCTargetE;
    end else if (w_resolve && w_hit_e && w_actual_taken) begin
      r_target[w_idx_e] <= PCTargetE;
    end
  end

  // Lookup reads registered state only, so same-cycle updates are not seen.
  assign PredTakenF  = r_valid[w_idx_f] & (r_tag[w_idx_f] == w_tag_f) & w_cnt[w_idx_f][1];
  assign PredTargetF = r_target[w_idx_f];

  assign w_mispredict = w_resolve &
                        ((w_actual_taken != PredTakenE) |
                         (w_actual_taken & (PredTargetE != PCTargetE)));

  assign w_unused = ^{PCF[1:0], PCE[1:0]};
`else
  assign PredTakenF   = 1'b0;
  assign PredTargetF  = '0;
  // Static not-taken: any taken control transfer is a redirect.
  assign w_mispredict = w_resolve & w_actual_taken;
  assign w_unused     = ^{clk, rst, PCF, PredTakenE, PredTargetE};
`endif

  assign RedirectE   = w_mispredict;
  assign FlushD      = w_mispredict;
  assign FlushE      = w_mispredict;
  assign RedirectPCE = w_actual_taken ? PCTargetE : (PCE + {{(WIDTH-3){1'b0}}, 3'b100});

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a
// randomized run against a table-level reference model.
module tb_branch_resolve;

  localparam int ENT = 16;
  localparam int IW  = 4;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  logic        BranchE;
  logic        JumpE;
  logic        BneE;
  logic        EQ;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        RedirectE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;

  int total;
  int bad;

  // Reference predictor state.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];

  branch_resolve #(.WIDTH(32), .ENTRIES(ENT)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .PCE         (PCE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .BneE        (BneE),
    .EQ          (EQ),
    .PCTargetE   (PCTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .StallE      (StallE),
    .RedirectE   (RedirectE),
    .RedirectPCE (RedirectPCE),
    .FlushD      (FlushD),
    .FlushE      (FlushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
  endfunction

  function automatic bit model_pred(logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
    int idx;
    idx = int'((pc >> 2) % ENT);
    return m_valid[idx] && (m_tag[idx] == (pc >> (IW + 2))) && (m_cnt[idx] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_tgt(logic [31:0] pc);
    return m_tgt[int'((pc >> 2) % ENT)];
  endfunction

  function automatic void model_update(logic [31:0] pc, bit taken, logic [31:0] tgt);
    int idx;
    idx = int'((pc >> 2) % ENT);
    if (m_valid[idx] && (m_tag[idx] == (pc >> (IW + 2)))) begin
      if (taken) begin
        m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        m_tgt[idx] = tgt;
      end else begin
        m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc >> (IW + 2);
      m_tgt[idx]   = tgt;
      m_cnt[idx]   = 2;
    end
  endfunction

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 3) << 2);
  endfunction

  task automatic idle();
    PCF = '0; PCE = '0; BranchE = 0; JumpE = 0; BneE = 0; EQ = 0;
    PCTargetE = '0; PredTakenE = 0; PredTargetE = '0; StallE = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One taken beq at 0x100 resolving to 0x140, with the given prediction.
  task automatic beq_100(input bit pt, input logic [31:0] ptg, input bit eq);
    idle();
    PCE = 32'h100; BranchE = 1; EQ = eq; PCTargetE = 32'h140;
    PredTakenE = pt; PredTargetE = ptg;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h0; pcs[2] = 32'h300; pcs[3] = 32'hFFFF_FFFC;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      PCF = pcs[i];
      #1;
      total++;
      if (PredTakenF !== 1'b0) begin
        bad++; $display("FAIL reset_pred pc=%h got=%b want=0", pcs[i], PredTakenF);
      end
    end
    // Combinational outputs follow inputs during reset; the update is dropped.
    idle();
    rst = 1; JumpE = 1; PCE = 32'h300; PCTargetE = 32'h340;
    #1;
    total++;
    if (RedirectE !== 1'b1 || RedirectPCE !== 32'h340) begin
      bad++; $display("FAIL reset_comb got=%b/%h want=1/00000340", RedirectE, RedirectPCE);
    end
    @(posedge clk);
    #1 rst = 0;
    idle();
    PCF = 32'h300;
    #1;
    total++;
    if (PredTakenF !== 1'b0) begin
      bad++; $display("FAIL reset_discard got=%b want=0", PredTakenF);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq_first();
    do_reset();
    idle();
    PCF = 32'h100;
    #1;
    total++;
    if (PredTakenF !== 1'b0) begin
      bad++; $display("FAIL beq_pred got=%b want=0", PredTakenF);
    end
    beq_100(1'b0, 32'h0, 1'b1);
    #1;
    total++;
    if ({RedirectE, FlushD, FlushE} !== 3'b111) begin
      bad++; $display("FAIL beq_redirect got=%b%b%b want=111", RedirectE, FlushD, FlushE);
    end
    total++;
    if (RedirectPCE !== 32'h140) begin
      bad++; $display("FAIL beq_pc got=%h want=00000140", RedirectPCE);
    end
    @(posedge clk); #1;
    idle();
  endtask

`ifdef BRANCH_PREDICT_EN
  task automatic test_predict();
    // Continues from test_beq_first: entry allocated at counter 2.
    repeat (2) begin
      beq_100(1'b1, 32'h140, 1'b1);
      @(posedge clk); #1;
    end
    idle();
    PCF = 32'h100;
    #1;
    total++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h140) begin
      bad++; $display("FAIL train_pred got=%b/%h want=1/00000140", PredTakenF, PredTargetF);
    end
    beq_100(1'b1, 32'h140, 1'b1);
    #1;
    total++;
    if (RedirectE !== 1'b0 || FlushD !== 1'b0 || FlushE !== 1'b0) begin
      bad++; $display("FAIL correct_pred got=%b want=0", RedirectE);
    end
    @(posedge clk); #1;
    // Counter now 3: two not-taken resolutions bring it to 1.
    beq_100(1'b1, 32'h140, 1'b0);
    #1;
    total++;
    if (RedirectE !== 1'b1 || RedirectPCE !== 32'h104) begin
      bad++; $display("FAIL nt_redirect got=%b/%h want=1/00000104", RedirectE, RedirectPCE);
    end
    @(posedge clk); #1;
    idle(); PCF = 32'h100; #1;
    total++;
    if (PredTakenF !== 1'b1) begin
      bad++; $display("FAIL nt_once got=%b want=1", PredTakenF);
    end
    beq_100(1'b1, 32'h140, 1'b0);
    @(posedge clk); #1;
    idle(); PCF = 32'h100; #1;
    total++;
    if (PredTakenF !== 1'b0) begin
      bad++; $display("FAIL nt_twice got=%b want=0", PredTakenF);
    end
    // Same-index lookup and taken update: old prediction this cycle.
    beq_100(1'b0, 32'h0, 1'b1);
    PCF = 32'h100;
    #1;
    total++;
    if (PredTakenF !== 1'b0) begin
      bad++; $display("FAIL same_idx_old got=%b want=0", PredTakenF);
    end
    @(posedge clk); #1;
    idle(); PCF = 32'h100; #1;
    total++;
    if (PredTakenF !== 1'b1) begin
      bad++; $display("FAIL same_idx_new got=%b want=1", PredTakenF);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_jump();
    idle();
    JumpE = 1; PCE = 32'h180; PCTargetE = 32'h200; PCF = 32'h200;
    #1;
    total++;
    if (RedirectE !== 1'b1 || RedirectPCE !== 32'h200) begin
      bad++; $display("FAIL jump got=%b/%h want=1/00000200", RedirectE, RedirectPCE);
    end
`ifndef BRANCH_PREDICT_EN
    total++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin
      bad++; $display("FAIL static_pred got=%b/%h want=0/0", PredTakenF, PredTargetF);
    end
`endif
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_wrap();
    idle();
    PCE = 32'hFFFF_FFFC; BranchE = 1; BneE = 1; EQ = 1; PCTargetE = 32'h500;
    PredTakenE = 1; PredTargetE = 32'h500;
    #1;
    total++;
    if (RedirectPCE !== 32'h0) begin
      bad++; $display("FAIL wrap_pc got=%h want=00000000", RedirectPCE);
    end
    total++;
`ifdef BRANCH_PREDICT_EN
    if (RedirectE !== 1'b1) begin
      bad++; $display("FAIL wrap_redirect got=%b want=1", RedirectE);
    end
`else
    if (RedirectE !== 1'b0) begin
      bad++; $display("FAIL wrap_redirect got=%b want=0", RedirectE);
    end
`endif
    // bne with EQ=0 is taken.
    EQ = 0;
    #1;
    total++;
    if (RedirectPCE !== 32'h500) begin
      bad++; $display("FAIL bne_taken_pc got=%h want=00000500", RedirectPCE);
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    beq_100(1'b0, 32'h0, 1'b1);
    PCTargetE = 32'h180; StallE = 1;
    #1;
    total++;
    if ({RedirectE, FlushD, FlushE} !== 3'b000) begin
      bad++; $display("FAIL stall_redirect got=%b%b%b want=000", RedirectE, FlushD, FlushE);
    end
    @(posedge clk); #1;
    idle(); PCF = 32'h100; #1;
    total++;
    if (PredTakenF !== 1'b0) begin
      bad++; $display("FAIL stall_table got=%b want=0", PredTakenF);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          act;
    bit          exp_mis;
    bit          exp_pt;
    logic [31:0] exp_rpc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 31) == 0);
      PCF         = rand_pc();
      PCE         = rand_pc();
      BranchE     = $urandom_range(0, 1);
      JumpE       = ($urandom_range(0, 3) == 0);
      BneE        = $urandom_range(0, 1);
      EQ          = $urandom_range(0, 1);
      StallE      = ($urandom_range(0, 5) == 0);
      PCTargetE   = 32'h2000 + ($urandom_range(0, 3) << 4);
      PredTakenE  = $urandom_range(0, 1);
      PredTargetE = $urandom_range(0, 1) ? PCTargetE : 32'h2000 + ($urandom_range(0, 3) << 4);
      #1;
      act = JumpE || (BranchE && (EQ != BneE));
`ifdef BRANCH_PREDICT_EN
      exp_mis = (BranchE || JumpE) && !StallE &&
                ((act != PredTakenE) || (act && (PredTargetE != PCTargetE)));
`else
      exp_mis = act && !StallE;
`endif
      exp_rpc = act ? PCTargetE : PCE + 32'd4;
      exp_pt  = model_pred(PCF);
      total++;
      if (PredTakenF !== exp_pt) begin
        bad++; $display("FAIL rnd_pred n=%0d pc=%h got=%b want=%b", n, PCF, PredTakenF, exp_pt);
      end
      total++;
      if (exp_pt && PredTargetF !== model_tgt(PCF)) begin
        bad++; $display("FAIL rnd_tgt n=%0d got=%h want=%h", n, PredTargetF, model_tgt(PCF));
      end
`ifndef BRANCH_PREDICT_EN
      total++;
      if (PredTargetF !== 32'h0) begin
        bad++; $display("FAIL rnd_static_tgt n=%0d got=%h want=0", n, PredTargetF);
      end
`endif
      total++;
      if (RedirectE !== exp_mis || FlushD !== exp_mis || FlushE !== exp_mis) begin
        bad++; $display("FAIL rnd_mis n=%0d got=%b%b%b want=%b", n, RedirectE, FlushD, FlushE,
                        exp_mis);
      end
      total++;
      if (RedirectPCE !== exp_rpc) begin
        bad++; $display("FAIL rnd_rpc n=%0d got=%h want=%h", n, RedirectPCE, exp_rpc);
      end
      @(posedge clk);
      if (rst) model_reset();
      else if ((BranchE || JumpE) && !StallE) model_update(PCE, act, PCTargetE);
      #1;
    end
    rst = 0;
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    idle();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_beq_first();
`ifdef BRANCH_PREDICT_EN
    test_predict();
`endif
    test_jump();
    test_wrap();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
